// File: rtl/comb_ckt_pkg.sv
// Shared constants and types for the comb_ckt detector.
// Default mask selects D2, D3, D4 and D7.
package comb_ckt_pkg;
  localparam logic [7:0] TRUTH_MASK_DEF = 8'b1001_1100;
  localparam int         CNT_W_DEF      = 8;
  typedef logic [7:0] comb_ckt_vec_t;
endpackage

// File: rtl/comb_ckt_fn.sv
// Pure combinational truth function.
// Produces the masked OR and the one-hot flag for an 8-bit input vector.
import comb_ckt_pkg::*;

module comb_ckt_fn (
  input  comb_ckt_vec_t d_i,
  input  comb_ckt_vec_t mask_i,
  output logic          out_o,
  output logic          onehot_o
);
  comb_ckt_vec_t d_dec;

  assign d_dec    = d_i - comb_ckt_vec_t'(1);
  assign out_o    = |(d_i & mask_i);
  // A nonzero value with no bit left after clearing its lowest set bit
  assign onehot_o = (d_i != '0) && ((d_i & d_dec) == '0);
endmodule

// File: rtl/comb_ckt.sv
// Fixed 8-input detector with registered copy and saturating hit counter.
// COMB_CKT_REG_OUT_EN: when defined, out is driven from the register.
import comb_ckt_pkg::*;

module comb_ckt #(
  parameter int            CNT_W      = CNT_W_DEF,
  parameter comb_ckt_vec_t TRUTH_MASK = TRUTH_MASK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D0,
  input  logic             D1,
  input  logic             D2,
  input  logic             D3,
  input  logic             D4,
  input  logic             D5,
  input  logic             D6,
  input  logic             D7,
  output logic             out,
  output logic             out_q,
  output logic             onehot,
  output logic [CNT_W-1:0] hit_cnt
);
  comb_ckt_vec_t    d;
  logic             out_c;
  logic             out_q_q;
  logic             out_q_d;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] hit_cnt_d;

  assign d = {D7, D6, D5, D4, D3, D2, D1, D0};

  comb_ckt_fn u_fn (
    .d_i      (d),
    .mask_i   (TRUTH_MASK),
    .out_o    (out_c),
    .onehot_o (onehot)
  );

  always_comb begin
    out_q_d   = out_c;
    hit_cnt_d = hit_cnt_q;
    if (out_c && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q_q   <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      out_q_q   <= out_q_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign out_q   = out_q_q;
  assign hit_cnt = hit_cnt_q;

`ifdef COMB_CKT_REG_OUT_EN
  assign out = out_q_q;
`else
  assign out = out_c;
`endif
endmodule

// File: tb/tb_comb_ckt.sv
// Randomized and directed bench for comb_ckt.
// Two instances: default counter width and a 4-bit counter.
module tb_comb_ckt;
  logic       clk;
  logic       rst;
  logic [7:0] d;

  logic       out8, outq8, oh8;
  logic [7:0] cnt8;
  logic       out4, outq4, oh4;
  logic [3:0] cnt4;

  int n_chk;
  int n_pass;

  // Reference state
  logic       m_q;
  int         m_c8;
  int         m_c4;

  localparam logic [7:0] MASK = 8'b1001_1100;

  comb_ckt dut (
    .clk(clk), .rst(rst),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .out(out8), .out_q(outq8), .onehot(oh8), .hit_cnt(cnt8)
  );

  comb_ckt #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
    .out(out4), .out_q(outq4), .onehot(oh4), .hit_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit f_out(logic [7:0] v);
    bit r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (v[i] === 1'b1 && MASK[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic bit f_oh(logic [7:0] v);
    return $countones(v) == 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q  <= 1'b0;
      m_c8 <= 0;
      m_c4 <= 0;
    end else begin
      m_q <= f_out(d);
      if (f_out(d) && m_c8 < 255) m_c8 <= m_c8 + 1;
      if (f_out(d) && m_c4 < 15)  m_c4 <= m_c4 + 1;
    end
  end

  function automatic bit exp_out();
`ifdef COMB_CKT_REG_OUT_EN
    return m_q;
`else
    return f_out(d);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_comb(input string tag);
    chk({tag, ".out"},     32'(out8), 32'(exp_out()));
    chk({tag, ".onehot"},  32'(oh8),  32'(f_oh(d)));
    chk({tag, ".onehot4"}, 32'(oh4),  32'(f_oh(d)));
  endtask

  task automatic chk_all(input string tag);
    chk_comb(tag);
    chk({tag, ".out_q"},  32'(outq8), 32'(m_q));
    chk({tag, ".out_q4"}, 32'(outq4), 32'(m_q));
    chk({tag, ".cnt"},    32'(cnt8),  32'(m_c8));
    chk({tag, ".cnt4"},   32'(cnt4),  32'(m_c4));
  endtask

  task automatic edges(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_all(tag);
    end
  endtask

  logic [7:0] dir_v [3];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    d      = 8'h00;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset");
    chk("reset.cnt_zero", 32'(cnt8), 32'd0);

    // One-hot sweep, checked 5 units after each change
    @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) begin
      d = 8'h01 << i;
      #5;
      chk_comb($sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d.onehot_const", i), 32'(oh8), 32'd1);
      #95;
    end

    // Multi-hot and all-zero patterns
    dir_v[0] = 8'h00;
    dir_v[1] = 8'h03;
    dir_v[2] = 8'h84;
    for (int i = 0; i < 3; i++) begin
      d = dir_v[i];
      #5;
      chk_comb($sformatf("dir_%0h", dir_v[i]));
      #95;
    end

    // Count five hits from reset
    @(negedge clk);
    rst = 1'b1;
    d   = 8'h04;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    edges(5, "count");
    chk("count.five", 32'(cnt8), 32'd5);

    // Saturate the 4-bit counter
    edges(20, "sat4");
    chk("sat4.max", 32'(cnt4), 32'hF);

    // Reset in mid-count with out high
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    edges(3, "pre_mid");
    chk("mid.cnt3", 32'(cnt8), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk_all("mid_rst");
    chk("mid_rst.cnt0", 32'(cnt8), 32'd0);
    rst = 1'b0;

    // Register latency on a 00 -> 80 step
    d = 8'h00;
    edges(2, "lat_lo");
    d = 8'h80;
    #1;
    chk_comb("lat_step");
    edges(1, "lat_hi");
    chk("lat_hi.out_q", 32'(outq8), 32'd1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      d   = 8'($urandom);
      rst = ($urandom_range(0, 19) == 0);
      #1;
      chk_comb("rnd_comb");
      edges(1, "rnd");
    end
    rst = 1'b0;

    // Saturate the default-width counter
    d = 8'h10;
    repeat (300) @(negedge clk);
    chk_all("sat8");
    chk("sat8.max", 32'(cnt8), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
